// File: rtl/cpu65_pkg.sv
// Shared definitions for the 65C02 interrupt front end: vector encodings and int_ctl states.
package cpu65_pkg;

  localparam logic [1:0] VEC_IRQ   = 2'b00;
  localparam logic [1:0] VEC_NMI   = 2'b01;
  localparam logic [1:0] VEC_RESET = 2'b10;

  typedef enum logic [1:0] {
    RST_HOLD = 2'b00,
    RUN      = 2'b01,
    WAIT     = 2'b10
  } int_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous active-low pin; presets to 1 (inactive) on reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr_q;
  logic [SYNC_STAGES-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '1;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt/reset front end for the 65C02 controller: reset stretch, NMI latch, vector select.
// Optional WAI support (rdy clock-enable, WAIT state) is built when WAIT_EN is defined.
module int_ctl
  import cpu65_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       sync,
  input  logic       I,
  input  logic       wai,
  output logic       core_reset,
  output logic       irq,
  output logic       I_eff,
  output logic [1:0] vec,
  output logic       rdy
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

  logic          irq_s;
  logic          nmi_s;
  logic          nmi_edge;
  logic          take;

  int_state_e    state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          nmi_dly_q,  nmi_dly_d;
  logic          nmi_pend_q, nmi_pend_d;
  logic [1:0]    vec_q,      vec_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
    .clk   (clk),
    .reset (reset),
    .d     (irq_n),
    .q     (irq_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk   (clk),
    .reset (reset),
    .d     (nmi_n),
    .q     (nmi_s)
  );

  assign nmi_edge   = nmi_dly_q & ~nmi_s;
  assign core_reset = (state_q == RST_HOLD);
  assign irq        = (state_q != RST_HOLD) & (nmi_pend_q | ~irq_s);
  assign I_eff      = I & ~nmi_pend_q;
  // Must match the controller's own take condition so the vector agrees with the sequence it runs.
  assign take       = sync & irq & ~I_eff & (state_q == RUN);
  assign vec        = vec_q;

`ifdef WAIT_EN
  assign rdy = (state_q != WAIT);
`else
  logic unused_wai;
  assign unused_wai = wai;
  assign rdy        = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nmi_dly_d  = nmi_s;
    nmi_pend_d = nmi_pend_q | (nmi_edge & (state_q != RST_HOLD));
    vec_d      = vec_q;

    case (state_q)
      RST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
`ifdef WAIT_EN
        if (wai) begin
          state_d = WAIT;
        end
`endif
      end
      WAIT: begin
`ifdef WAIT_EN
        // Wake on any pending request, masked or not.
        if (~irq_s || nmi_pend_q) begin
          state_d = RUN;
        end
`endif
      end
      default: state_d = state_q;
    endcase

    if (take) begin
      if (nmi_pend_q) begin
        vec_d      = VEC_NMI;
        nmi_pend_d = nmi_edge;
      end else begin
        vec_d = VEC_IRQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_HOLD;
      cnt_q      <= '0;
      nmi_dly_q  <= 1'b1;
      nmi_pend_q <= 1'b0;
      vec_q      <= VEC_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nmi_dly_q  <= nmi_dly_d;
      nmi_pend_q <= nmi_pend_d;
      vec_q      <= vec_d;
    end
  end

endmodule

// File: tb/tb_int_ctl.sv
// Directed self-checking bench for int_ctl (default parameters).
module tb_int_ctl;

  logic       clk;
  logic       reset;
  logic       irq_n;
  logic       nmi_n;
  logic       sync;
  logic       i_flag;
  logic       wai;
  logic       core_reset;
  logic       irq;
  logic       i_eff;
  logic [1:0] vec;
  logic       rdy;

  int checks = 0;
  int errors = 0;

  int_ctl #(.RESET_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_n      (irq_n),
    .nmi_n      (nmi_n),
    .sync       (sync),
    .I          (i_flag),
    .wai        (wai),
    .core_reset (core_reset),
    .irq        (irq),
    .I_eff      (i_eff),
    .vec        (vec),
    .rdy        (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    irq_n  = 1'b0;
    nmi_n  = 1'b1;
    sync   = 1'b0;
    i_flag = 1'b1;
    wai    = 1'b0;

    // Reset state, with irq_n already low to prove irq is forced off in the hold
    step(); step(); step();
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_vec", vec, 2'b10);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_ieff", i_eff, 1'b1);

    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rel_core_reset_%0d", k), core_reset, (k < 4) ? 1'b1 : 1'b0);
      chk($sformatf("rel_irq_%0d", k), irq, (k == 4) ? 1'b1 : 1'b0);
    end
    chk("rel_vec", vec, 2'b10);

    // Masked IRQ: no take
    sync = 1'b1;
    step();
    chk("irq_masked_vec", vec, 2'b10);
    chk("irq_masked_ieff", i_eff, 1'b1);
    i_flag = 1'b0;
    step();
    sync = 1'b0;
    chk("irq_take_vec", vec, 2'b00);

    // NMI edge, latched after three edges, unmaskable
    irq_n  = 1'b1;
    i_flag = 1'b1;
    step(); step(); step();
    chk("irq_released", irq, 1'b0);
    nmi_n = 1'b0;
    step();
    chk("nmi_lat1", irq, 1'b0);
    step();
    chk("nmi_lat2", irq, 1'b0);
    step();
    chk("nmi_lat3", irq, 1'b1);
    chk("nmi_ieff", i_eff, 1'b0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("nmi_take_vec", vec, 2'b01);
    chk("nmi_take_irq", irq, 1'b0);
    chk("nmi_take_ieff", i_eff, 1'b1);

    // NMI and IRQ together: NMI first, then IRQ
    nmi_n = 1'b1;
    step(); step(); step();
    nmi_n = 1'b0;
    irq_n = 1'b0;
    step(); step(); step();
    chk("both_irq", irq, 1'b1);
    sync = 1'b1;
    step();
    chk("both_first_vec", vec, 2'b01);
    i_flag = 1'b0;
    step();
    sync = 1'b0;
    chk("both_second_vec", vec, 2'b00);

    // Reset while an NMI is pending
    i_flag = 1'b1;
    irq_n  = 1'b1;
    nmi_n  = 1'b1;
    step(); step(); step();
    nmi_n = 1'b0;
    step(); step(); step();
    chk("mid_pend_irq", irq, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_core_reset", core_reset, 1'b1);
    chk("mid_vec", vec, 2'b10);
    chk("mid_irq", irq, 1'b0);
    step();
    reset = 1'b0;
    step(); step();
    chk("mid_count_partial", core_reset, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("restart_core_reset_%0d", k), core_reset, (k < 4) ? 1'b1 : 1'b0);
    end
    chk("restart_irq", irq, 1'b0);
    chk("restart_vec", vec, 2'b10);

    // WAI handling
    wai = 1'b1;
    step();
    wai = 1'b0;
`ifdef WAIT_EN
    chk("wait_rdy_low", rdy, 1'b0);
    irq_n = 1'b0;
    n = 0;
    while (!rdy && n < 3) begin
      step();
      n++;
    end
    chk("wait_exit_rdy", rdy, 1'b1);
    chk("wait_exit_vec", vec, 2'b10);
`else
    chk("nowait_rdy", rdy, 1'b1);
    irq_n = 1'b0;
    n = 0;
    while (n < 3) begin
      step();
      n++;
    end
    chk("nowait_rdy_hold", rdy, 1'b1);
    chk("nowait_vec", vec, 2'b10);
`endif
    irq_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctl.md
Name: int_ctl

Overview:
- Interrupt and reset front end for the 65C02 core. Sits directly upstream of the microcode controller and drives its `irq`, `reset` and `I` inputs.
- Synchronises the external `irq_n` and `nmi_n` pins and edge-detects NMI into a pending latch.
- Stretches the core reset and tells the vector logic which vector (RESET/NMI/IRQ) the current interrupt sequence must fetch.

Parameters:
- RESET_CYCLES, 4: number of clk cycles `core_reset` stays high after `reset` deasserts. Legal range ≥1.
- SYNC_STAGES, 2: synchroniser depth on `irq_n`/`nmi_n`. Legal range ≥2.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset; one clock domain
- irq_n  in  1  external IRQ, level, active-low, asynchronous
- nmi_n  in  1  external NMI, falling-edge, asynchronous
- sync  in  1  from controller; high in the opcode-decode cycle
- I  in  1  processor I flag from the status register
- wai  in  1  WAI instruction executing (used only with WAIT_EN)
- core_reset  out  1  stretched reset to the controller
- irq  out  1  interrupt request to the controller
- I_eff  out  1  effective mask to the controller's I input
- vec  out  2  vector select: 2'b00 IRQ/BRK ($FFFE), 2'b01 NMI ($FFFA), 2'b10 RESET ($FFFC)
- rdy  out  1  core clock-enable; low while waiting

Behaviour:
- Reset values (async, while reset=1):
  - Synchroniser flops = 1 (inactive); NMI edge flop = 1.
  - nmi_pend=0, core_reset=1, vec=2'b10, rdy=1, counter=0, state=RST_HOLD.
- Synchronisers: SYNC_STAGES flops per pin. irq_s/nmi_s denote the last stage.
- core_reset:
  - Counter increments each cycle in RST_HOLD.
  - When the counter reaches RESET_CYCLES-1, state goes to RUN and core_reset drops on the next edge, i.e. exactly RESET_CYCLES rising edges after reset falls.
  - Reasserting reset mid-count restarts the count from 0.
- NMI edge detect:
  - nmi_d <= nmi_s. An edge is `nmi_d & ~nmi_s`; on an edge, nmi_pend sets on the next edge.
  - Pin-to-nmi_pend latency = SYNC_STAGES+1 cycles.
  - Further edges while pending merge into one service.
  - Edges are ignored in RST_HOLD.
- irq = nmi_pend | ~irq_s, combinational; forced 0 in RST_HOLD.
- I_eff = I & ~nmi_pend, so an NMI is never masked.
- take = sync & irq & ~I_eff & (state==RUN). This matches the controller's own take condition.
- On take:
  - If nmi_pend: vec<=2'b01 and nmi_pend<=0. If a new edge is detected in the same cycle, nmi_pend stays 1.
  - Otherwise: vec<=2'b00.
- vec holds its value until the next take or reset. NMI has priority over IRQ.
- IRQ is level-sensitive: if irq_n returns high before a take, nothing is recorded.
- BRK is not seen by this block; vec is 2'b00 after reset-free operation unless an NMI was last taken, and BRK uses the IRQ vector.
- States: RST_HOLD → RUN (count done); RUN → WAIT (WAIT_EN only); WAIT → RUN.

Optional Feature:
- WAIT_EN defined:
  - In RUN, wai=1 moves the state to WAIT; rdy=0 from the next cycle.
  - WAIT exits to RUN when ~irq_s or nmi_pend, regardless of I; rdy=1 on the following cycle.
  - take is blocked while in WAIT.
- WAIT_EN undefined: wai is ignored, rdy is constant 1, and the WAIT state does not exist.

Decomposition:
- Shared package cpu65_pkg holds:
  - vector encodings VEC_IRQ=2'b00, VEC_NMI=2'b01, VEC_RESET=2'b10;
  - the int_ctl state enum RST_HOLD/RUN/WAIT.
- Sub-module sync_ff: parameterised SYNC_STAGES synchroniser with async preset-to-1, instantiated twice.

Test Plan:
- Reset release: reset high 3 cycles then low → core_reset falls exactly 4 edges later; vec=2'b10, irq=0 throughout.
- IRQ masked/unmasked:
  - irq_n=0 with I=1, sync pulsed → irq=1 and vec stays 2'b10.
  - Then I=0 with sync → vec=2'b00.
- NMI: falling edge on nmi_n, I=1 → nmi_pend after 3 cycles, I_eff=0. On the next sync, vec=2'b01, nmi_pend=0 and irq=0 (irq_n high).
- NMI+IRQ same cycle: both active at sync → vec=2'b01. Next sync with irq_n still low → vec=2'b00.
- Reset mid-operation: nmi_pend=1 and counter running, assert reset → nmi_pend=0, core_reset=1, vec=2'b10; the count restarts at 0.
- WAIT_EN: wai=1 → rdy=0 next cycle. irq_n=0 with I=1 → rdy=1 within 3 cycles and no take.
